// File: rtl/hisoc_mon_pkg.sv
// Shared encodings for the HISOC ISA-test pass/fail monitor.
package hisoc_mon_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } mon_state_e;

   localparam logic [4:0] REG_TESTNUM = 5'd3;
   localparam logic [4:0] REG_END     = 5'd26;
   localparam logic [4:0] REG_PASS    = 5'd27;

   localparam int unsigned END_VALUE  = 1;
   localparam int unsigned PASS_VALUE = 1;

endpackage

// File: rtl/hisoc_test_monitor.sv
// Snoops RVSEED register-file writeback, detects the x26 end marker and
// produces a registered pass/fail/timeout verdict after a drain window.
module hisoc_test_monitor
   import hisoc_mon_pkg::*;
#(
   parameter int unsigned CPU_WIDTH      = 32,
   parameter int unsigned DRAIN_CYCLES   = 4,
   parameter int unsigned TIMEOUT_CYCLES = 2000,
   parameter int unsigned CNT_WIDTH      = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 enable,
   input  logic                 wb_en,
   input  logic [4:0]           wb_addr,
   input  logic [CPU_WIDTH-1:0] wb_data,
   output logic                 test_done,
   output logic                 test_pass,
   output logic                 test_timeout,
   output logic [CPU_WIDTH-1:0] fail_testnum,
   output logic [CNT_WIDTH-1:0] cycle_cnt
);

   localparam int unsigned DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

   mon_state_e           state_q, state_d;
   logic [DW-1:0]        drain_q, drain_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic [CPU_WIDTH-1:0] x3_q, x3_d;
   logic [CPU_WIDTH-1:0] x26_q, x26_d;
   logic [CPU_WIDTH-1:0] x27_q, x27_d;
   logic                 done_q, done_d;
   logic                 pass_q, pass_d;
   logic                 tmo_q, tmo_d;
   logic [CPU_WIDTH-1:0] fnum_q, fnum_d;

   logic end_hit;
   logic pass_now;

   assign end_hit = wb_en && (wb_addr == REG_END) && (wb_data == CPU_WIDTH'(END_VALUE));

   always_comb begin
      state_d  = state_q;
      drain_d  = drain_q;
      cnt_d    = cnt_q;
      x3_d     = x3_q;
      x26_d    = x26_q;
      x27_d    = x27_q;
      done_d   = done_q;
      pass_d   = pass_q;
      tmo_d    = tmo_q;
      fnum_d   = fnum_q;
      pass_now = 1'b0;

      if (wb_en && ((state_q == RUN) || (state_q == DRAIN))) begin
         if (wb_addr == REG_TESTNUM) x3_d  = wb_data;
         if (wb_addr == REG_END)     x26_d = wb_data;
         if (wb_addr == REG_PASS)    x27_d = wb_data;
      end

      case (state_q)
         IDLE: begin
            state_d = RUN;
            cnt_d   = '0;
         end
         RUN: begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
            if (end_hit) begin
               state_d = DRAIN;
               drain_d = DW'(DRAIN_CYCLES - 1);
            end else if (cnt_q == CNT_WIDTH'(TIMEOUT_CYCLES - 1)) begin
               state_d = DONE;
               done_d  = 1'b1;
               tmo_d   = 1'b1;
               pass_d  = 1'b0;
               fnum_d  = x3_q;
            end
         end
         DRAIN: begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
            if (drain_q == '0) begin
               // Compare next-state shadows so a flag written in the final
               // drain cycle still counts.
               pass_now = (x27_d == CPU_WIDTH'(PASS_VALUE));
               state_d  = DONE;
               done_d   = 1'b1;
               pass_d   = pass_now;
               fnum_d   = pass_now ? '0 : x3_d;
            end else begin
               drain_d = drain_q - DW'(1);
            end
         end
         default: ;
      endcase

      if (!enable) begin
         state_d = IDLE;
         drain_d = '0;
         cnt_d   = '0;
         x3_d    = '0;
         x26_d   = '0;
         x27_d   = '0;
         done_d  = 1'b0;
         pass_d  = 1'b0;
         tmo_d   = 1'b0;
         fnum_d  = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         drain_q <= '0;
         cnt_q   <= '0;
         x3_q    <= '0;
         x26_q   <= '0;
         x27_q   <= '0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         tmo_q   <= 1'b0;
         fnum_q  <= '0;
      end else begin
         state_q <= state_d;
         drain_q <= drain_d;
         cnt_q   <= cnt_d;
         x3_q    <= x3_d;
         x26_q   <= x26_d;
         x27_q   <= x27_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
         tmo_q   <= tmo_d;
         fnum_q  <= fnum_d;
      end
   end

   assign test_done    = done_q;
   assign test_pass    = pass_q;
   assign test_timeout = tmo_q;
   assign fail_testnum = fnum_q;
   assign cycle_cnt    = cnt_q;

endmodule

// File: tb/tb_hisoc_test_monitor.sv
// Randomized and directed bench for hisoc_test_monitor against a
// cycle-event reference model.
module tb_hisoc_test_monitor;

   localparam int unsigned CW  = 32;
   localparam int unsigned NW  = 32;
   localparam int unsigned DRN = 4;
   localparam int unsigned TMO = 2000;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          enable = 1'b0;
   logic          wb_en = 1'b0;
   logic [4:0]    wb_addr = '0;
   logic [CW-1:0] wb_data = '0;
   logic          test_done, test_pass, test_timeout;
   logic [CW-1:0] fail_testnum;
   logic [NW-1:0] cycle_cnt;

   int n_checks = 0;
   int n_errors = 0;

   hisoc_test_monitor #(
      .CPU_WIDTH(CW),
      .DRAIN_CYCLES(DRN),
      .TIMEOUT_CYCLES(TMO),
      .CNT_WIDTH(NW)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .enable(enable),
      .wb_en(wb_en),
      .wb_addr(wb_addr),
      .wb_data(wb_data),
      .test_done(test_done),
      .test_pass(test_pass),
      .test_timeout(test_timeout),
      .fail_testnum(fail_testnum),
      .cycle_cnt(cycle_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference model: a test is "started", then optionally "ended" at some
   // age since the end marker; the verdict is formed when that age hits DRN.
   bit            m_started, m_done, m_pass, m_tmo;
   int            m_age;
   logic [CW-1:0] m_sh [32];
   logic [CW-1:0] m_fnum;
   logic [NW-1:0] m_cnt;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      m_started = 0;
      m_done    = 0;
      m_pass    = 0;
      m_tmo     = 0;
      m_age     = -1;
      m_fnum    = '0;
      m_cnt     = '0;
      for (int i = 0; i < 32; i++) m_sh[i] = '0;
   endtask

   task automatic model_edge();
      logic [CW-1:0] old_x3;
      logic [NW-1:0] old_cnt;
      if (!enable) begin
         model_clear();
      end else if (!m_started) begin
         m_started = 1;
         m_cnt     = '0;
      end else if (!m_done) begin
         old_x3  = m_sh[3];
         old_cnt = m_cnt;
         if (wb_en && (wb_addr == 3 || wb_addr == 26 || wb_addr == 27))
            m_sh[wb_addr] = wb_data;
         m_cnt = m_cnt + 1;
         if (m_age < 0) begin
            if (wb_en && wb_addr == 26 && wb_data == 1) begin
               m_age = 0;
            end else if (old_cnt == NW'(TMO - 1)) begin
               m_done = 1;
               m_tmo  = 1;
               m_pass = 0;
               m_fnum = old_x3;
            end
         end else begin
            m_age++;
            if (m_age == DRN) begin
               m_done = 1;
               m_pass = (m_sh[27] == 1);
               m_fnum = m_pass ? '0 : m_sh[3];
            end
         end
      end
   endtask

   task automatic check_all(input string ph);
      check({ph, "/done"},    test_done,    m_done);
      check({ph, "/pass"},    test_pass,    m_pass);
      check({ph, "/timeout"}, test_timeout, m_tmo);
      check({ph, "/fnum"},    fail_testnum, m_fnum);
      check({ph, "/cnt"},     cycle_cnt,    m_cnt);
   endtask

   string phase = "reset";

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      check_all(phase);
   endtask

   task automatic wb(input logic [4:0] a, input logic [CW-1:0] d);
      wb_en   = 1'b1;
      wb_addr = a;
      wb_data = d;
   endtask

   task automatic wb_idle();
      wb_en   = 1'b0;
      wb_addr = 5'($urandom);
      wb_data = $urandom;
   endtask

   task automatic start_test();
      enable = 1'b0;
      wb_idle();
      tick();
      enable = 1'b1;
      tick();
   endtask

   task automatic wait_done(input int bound, output int lat);
      lat = 0;
      while (!test_done && lat < bound) begin
         tick();
         lat++;
      end
   endtask

   initial begin
      int lat;
      model_clear();
      #12;
      check_all("reset");
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      phase = "pass";
      start_test();
      for (int k = 1; k <= 20; k++) begin
         if (k == 10)      wb(27, 1);
         else if (k == 12) wb(3, 5);
         else if (k == 20) wb(26, 1);
         else              wb_idle();
         tick();
      end
      wb_idle();
      wait_done(20, lat);
      check("pass_lat", lat, 4);
      check("pass_flag", test_pass, 1);
      check("pass_fnum", fail_testnum, 0);
      check("pass_cnt", cycle_cnt, 24);

      phase = "fail";
      start_test();
      wb(3, 7);  tick();
      wb(27, 0); tick();
      wb(26, 1); tick();
      wb_idle();
      wait_done(20, lat);
      check("fail_lat", lat, 4);
      check("fail_flag", test_pass, 0);
      check("fail_fnum", fail_testnum, 7);

      phase = "late";
      start_test();
      wb(26, 1); tick();
      wb_idle(); repeat (3) tick();
      wb(27, 1); tick();
      check("late_done", test_done, 1);
      check("late_pass", test_pass, 1);
      start_test();
      wb(27, 0); tick();
      wb(26, 1); tick();
      wb_idle();
      wait_done(20, lat);
      wb(27, 1); tick();
      wb_idle(); tick();
      check("after_done_pass", test_pass, 0);

      phase = "timeout";
      start_test();
      wb_idle();
      wait_done(TMO + 100, lat);
      check("tmo_lat", lat, TMO);
      check("tmo_flag", test_timeout, 1);
      check("tmo_pass", test_pass, 0);
      start_test();
      repeat (TMO - 1) tick();
      wb(26, 1); tick();
      check("tmo_race_flag", test_timeout, 0);
      wb_idle();
      wait_done(20, lat);
      check("tmo_race_lat", lat, 4);
      check("tmo_race_flag2", test_timeout, 0);

      phase = "ignored";
      start_test();
      wb(26, 2); tick();
      wb(0, 1);  tick();
      wb_en = 1'b0; wb_addr = 26; wb_data = 1; tick();
      check("ign_done", test_done, 0);
      wb(26, 1); tick();
      wb_idle();
      wait_done(20, lat);
      check("ign_lat", lat, 4);

      phase = "clear";
      start_test();
      wb(3, 9);  tick();
      wb(27, 1); tick();
      wb(26, 1); tick();
      wb_idle(); tick();
      enable = 1'b0; tick();
      enable = 1'b1; tick();
      check("clr_cnt", cycle_cnt, 0);
      wb(26, 1); tick();
      wb_idle();
      wait_done(20, lat);
      check("clr_pass", test_pass, 0);
      check("clr_fnum", fail_testnum, 0);

      phase = "async";
      start_test();
      wb(3, 9);  tick();
      wb(27, 1); tick();
      wb(26, 1); tick();
      wb_idle(); tick();
      #2;
      rst_n = 1'b0;
      model_clear();
      #1;
      check_all("async_now");
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      check("async_cnt", cycle_cnt, 0);
      wb(26, 1); tick();
      wb_idle();
      wait_done(20, lat);
      check("async_pass", test_pass, 0);
      check("async_fnum", fail_testnum, 0);

      phase = "random";
      start_test();
      for (int i = 0; i < 3000; i++) begin
         enable = ($urandom_range(0, 39) != 0);
         wb_en  = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 4))
            0:       wb_addr = 3;
            1:       wb_addr = 26;
            2:       wb_addr = 27;
            3:       wb_addr = 0;
            default: wb_addr = 5'($urandom);
         endcase
         case ($urandom_range(0, 3))
            0:       wb_data = 0;
            1, 2:    wb_data = 1;
            default: wb_data = $urandom;
         endcase
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
